// File: rtl/ahb_sram_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_slave_if
// Brief    : AHB-Lite signal bundle between a master-side model and the SRAM
//            responder.
// Revision : 1.0
// ============================================================================
interface ahb_sram_slave_if #(
    parameter int ADDR_BITS = 32
) ();

    logic                 HSEL;
    logic [ADDR_BITS-1:0] HADDR;
    logic [1:0]           HTRANS;
    logic                 HWRITE;
    logic [2:0]           HSIZE;
    logic [31:0]          HWDATA;
    logic                 HREADY;
    logic [31:0]          HRDATA;
    logic                 HREADYOUT;
    logic                 HRESP;

    modport master (
        output HSEL,
        output HADDR,
        output HTRANS,
        output HWRITE,
        output HSIZE,
        output HWDATA,
        output HREADY,
        input  HRDATA,
        input  HREADYOUT,
        input  HRESP
    );

    modport slave (
        input  HSEL,
        input  HADDR,
        input  HTRANS,
        input  HWRITE,
        input  HSIZE,
        input  HWDATA,
        input  HREADY,
        output HRDATA,
        output HREADYOUT,
        output HRESP
    );

endinterface
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_slave
// Brief    : AHB-Lite SRAM responder with programmable wait states, byte-lane
//            writes and a two-cycle ERROR response for illegal transfers.
// Revision : 1.0
// ============================================================================
module ahb_sram_slave #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    ahb_sram_slave_if.slave bus
);

    localparam int         c_IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] c_WAIT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_WAIT = 3'd1;
    localparam logic [2:0] c_ST_DATA = 3'd2;
    localparam logic [2:0] c_ST_ERR1 = 3'd3;
    localparam logic [2:0] c_ST_ERR2 = 3'd4;

    logic [2:0]         r_state;
    logic               r_hreadyout;
    logic               r_hresp;
    logic [3:0]         r_cnt;
    logic               r_write;
    logic [3:0]         r_be;
    logic [c_IDX_W-1:0] r_idx;

    logic               w_accept;
    logic               w_bad_size;
    logic               w_misalign;
    logic               w_oob;
    logic               w_illegal;
    logic [3:0]         w_be;
    logic               w_commit;
    logic [31:0]        w_rd_word;

    // r_hreadyout gating keeps a protocol-violating HREADY from starting a
    // transfer while this slave is still stalling its own data phase.
    assign w_accept   = bus.HSEL & bus.HREADY & bus.HTRANS[1] & r_hreadyout;

    assign w_bad_size = (bus.HSIZE > 3'd2);
    assign w_misalign = ((bus.HSIZE == 3'd1) & bus.HADDR[0]) |
                        ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'b00));
    assign w_oob      = ({18'd0, bus.HADDR[15:2]} >= 32'(MEM_WORDS));
    assign w_illegal  = w_bad_size | w_misalign | w_oob;

    always_comb begin
        w_be = 4'b0000;
        case (bus.HSIZE)
            3'd0:    w_be = 4'b0001 << bus.HADDR[1:0];
            3'd1:    w_be = bus.HADDR[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= c_ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_be        <= 4'b0000;
            r_idx       <= '0;
        end else if (w_accept) begin
            r_write <= bus.HWRITE;
            r_be    <= w_be;
            r_idx   <= bus.HADDR[c_IDX_W+1:2];
            if (w_illegal) begin
                r_state     <= c_ST_ERR1;
                r_hreadyout <= 1'b0;
                r_hresp     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
                r_state     <= c_ST_WAIT;
                r_cnt       <= c_WAIT_LOAD;
                r_hreadyout <= 1'b0;
                r_hresp     <= 1'b0;
            end else begin
                r_state     <= c_ST_DATA;
                r_hreadyout <= 1'b1;
                r_hresp     <= 1'b0;
            end
        end else begin
            case (r_state)
                c_ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= c_ST_DATA;
                        r_hreadyout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_ERR1: begin
                    r_state     <= c_ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                end
            endcase
        end
    end

    // Errored transfers never reach DATA, so they can never commit.
    assign w_commit = (r_state == c_ST_DATA) & r_write;

    generate
        for (genvar b = 0; b < 4; b++) begin : g_lane
            logic [7:0] r_mem [MEM_WORDS];

            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn) begin
                    for (int i = 0; i < MEM_WORDS; i++) begin
                        r_mem[i] <= 8'h00;
                    end
                end else if (w_commit && r_be[b]) begin
                    r_mem[r_idx] <= bus.HWDATA[8*b +: 8];
                end
            end

            assign w_rd_word[8*b +: 8] = r_mem[r_idx];
        end
    endgenerate

    assign bus.HRDATA    = ((r_state == c_ST_WAIT) || (r_state == c_ST_DATA)) ? w_rd_word : 32'h0;
    assign bus.HREADYOUT = r_hreadyout;
    assign bus.HRESP     = r_hresp;

endmodule
`default_nettype wire
